// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS-subset datapath with an internal control FSM,
// a register file, a data SRAM and an ALU with signed-overflow trapping.
// One instruction is accepted per handshake and retires 1..4 cycles later.
module mc_datapath #(
    parameter int DW        = 32,
    parameter int NREG      = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   inst,
    input  logic          inst_valid,
    output logic          inst_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic          ovf,
    output logic          branch_taken,
    output logic          illegal
);
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DEC  = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    logic [2:0]    state_q, state_d;
    logic [31:0]   ir_q;
    logic [DW-1:0] a_q, b_q, alu_q, mdr_q, rd_data_q;
    logic          ovf_q;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] mem [MEM_DEPTH];

    // Instruction fields, all taken from the latched IR.
    logic [5:0]    op, funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx, wb_dst;
    logic [31:0]   imm32;
    logic [DW-1:0] imm;

    assign op     = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs_idx = ir_q[21 +: RW];
    assign rt_idx = ir_q[16 +: RW];
    assign rd_idx = ir_q[11 +: RW];
    assign imm32  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm    = imm32[DW-1:0];

    logic is_r, is_lw, is_sw, is_addi, is_beq, r_legal, is_illegal;

    assign is_r       = (op == OP_R);
    assign is_lw      = (op == OP_LW);
    assign is_sw      = (op == OP_SW);
    assign is_addi    = (op == OP_ADDI);
    assign is_beq     = (op == OP_BEQ);
    assign r_legal    = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                        (funct == F_OR)  || (funct == F_SLT);
    assign is_illegal = !(is_r && r_legal) && !is_lw && !is_sw && !is_addi && !is_beq;
    assign wb_dst     = is_r ? rd_idx : rt_idx;

    // ALU: R-type uses B, everything else uses the sign-extended immediate.
    logic [DW-1:0] b_op, sum, diff, alu_res;
    logic          alu_ovf, slt_bit;

    assign b_op    = is_r ? b_q : imm;
    assign sum     = a_q + b_op;
    assign diff    = a_q - b_q;
    assign slt_bit = ($signed(a_q) < $signed(b_q));

    // Select the ALU result and flag signed overflow for add/sub/addi only.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res = sum;
        alu_ovf = 1'b0;
        if (is_r) begin
            case (funct)
                F_ADD: alu_ovf = (a_q[DW-1] == b_q[DW-1]) && (sum[DW-1] != a_q[DW-1]);
                F_SUB: begin
                    alu_res = diff;
                    alu_ovf = (a_q[DW-1] != b_q[DW-1]) && (diff[DW-1] != a_q[DW-1]);
                end
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_SLT:   alu_res = {{(DW-1){1'b0}}, slt_bit};
                default: alu_res = sum;
            endcase
        end else if (is_addi) begin
            alu_ovf = (a_q[DW-1] == imm[DW-1]) && (sum[DW-1] != a_q[DW-1]);
        end
    end

    // Control FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (inst_valid) state_d = S_DEC;
            S_DEC:  state_d = is_illegal ? S_IDLE : S_EX;
            S_EX: begin
                if (is_beq)              state_d = S_IDLE;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM:   state_d = is_lw ? S_WB : S_IDLE;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write-back: suppressed on a trapped overflow; r0 is never written.
    logic          wb_en;
    logic [DW-1:0] wb_val;

    assign wb_en  = (state_q == S_WB) && !ovf_q;
    assign wb_val = is_lw ? mdr_q : alu_q;

    // Status outputs are decoded from the current state so they pulse with done.
    assign inst_ready   = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign done         = ((state_q == S_DEC) && is_illegal) ||
                          ((state_q == S_EX)  && is_beq) ||
                          ((state_q == S_MEM) && is_sw) ||
                          (state_q == S_WB);
    assign illegal      = (state_q == S_DEC) && is_illegal;
    assign branch_taken = (state_q == S_EX) && is_beq && (a_q == b_q);
    assign ovf          = (state_q == S_WB) && ovf_q;
    assign rd_data      = wb_en ? wb_val : rd_data_q;

    // FSM state, IR, A/B, ALUOut and register file; all cleared by reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && inst_valid) ir_q <= inst;
            if (state_q == S_DEC) begin
                a_q <= regs_q[rs_idx];
                b_q <= regs_q[rt_idx];
            end
            if (state_q == S_EX) begin
                alu_q <= alu_res;
                ovf_q <= alu_ovf;
            end
            if (wb_en) begin
                rd_data_q <= wb_val;
                if (wb_dst != '0) regs_q[wb_dst] <= wb_val;
            end
        end
    end

    // Data SRAM: synchronous read into MDR, write of B; address wraps on the low bits.
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;

    assign mem_addr = alu_q[AW+1:2];
    assign mem_we   = (state_q == S_MEM) && is_sw && !rst;
    assign mem_re   = (state_q == S_MEM) && is_lw;

    // NOTE: the SRAM array has no reset; its contents survive rst like a real macro.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= b_q;
        if (mem_re) mdr_q <= mem[mem_addr];
    end

    // Fields not consumed at every parameterisation (shamt, upper index/address bits).
    logic unused_bits;
    assign unused_bits = ^{ir_q, imm32, alu_q};

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Parametrised multicycle successor to the single-cycle datapath. Accepts one MIPS-subset instruction per valid/ready handshake and executes it over 2–4 cycles through an internal control FSM. Contains its own register file, data SRAM and ALU. Adds width, register-count and memory-depth generics, signed-overflow trapping, branch resolution and illegal-opcode reporting.

## Interface
- DW, 32: datapath width; legal range 16..32.
- NREG, 32: register count; power of 2, 2..32. Register 0 is hardwired to 0.
- MEM_DEPTH, 256: data SRAM depth in DW-bit words; power of 2.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- inst  in  32  instruction word; sampled only on handshake.
- inst_valid  in  1  instruction offered.
- inst_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at instruction retirement.
- rd_data  out  DW  last result: load data for lw, ALU result for R-type/addi; holds otherwise.
- ovf  out  1  one-cycle pulse with done when add/sub/addi overflows (signed).
- branch_taken  out  1  one-cycle pulse with done for beq when rs==rt.
- illegal  out  1  one-cycle pulse with done for an unsupported opcode/funct.

## Operation
- Decode uses standard MIPS fields: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
- Register indices use the low log2(NREG) bits of each field.
- The immediate is sign-extended to 32 bits, then truncated to DW.
- Supported instructions:
  - R-type (op 000000), by funct: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed compare; result 1/0).
  - lw 100011; sw 101011; addi 001000; beq 000100.
  - Anything else is illegal: no state change.
- Write destination: rd for R-type; rt for lw/addi.
- Memory word address = ALU result bits [log2(MEM_DEPTH)+1:2]. Upper bits are ignored, so addresses wrap.
- Overflow on add/sub/addi suppresses the register write, leaves rd_data unchanged, and pulses ovf.
- Writes to register 0 are discarded; reads of register 0 return 0.
- FSM states: IDLE, DEC, EX, MEM, WB.
  - IDLE -> DEC on inst_valid & inst_ready; inst is latched into IR.
  - DEC: read rs/rt into A/B.
    - illegal -> IDLE with done+illegal.
    - otherwise -> EX.
  - EX: ALUOut <= A op (B or imm).
    - beq -> IDLE with done, and branch_taken if A==B.
    - lw/sw -> MEM.
    - R-type/addi -> WB.
  - MEM:
    - sw: write B to SRAM at end of cycle; done; -> IDLE.
    - lw: MDR <= SRAM[addr]; -> WB.
  - WB: write the register file at end of cycle; update rd_data; done (with ovf if trapped); -> IDLE.
- Reset values:
  - state IDLE; inst_ready 1; busy 0; done/ovf/branch_taken/illegal 0; rd_data 0.
  - All registers cleared to 0.
  - SRAM is not cleared.

## Timing
- Cycle 0 is the handshake cycle. inst_valid while busy is ignored; no buffering.
- done asserts in this cycle after acceptance:
  - illegal: cycle 1.
  - beq: cycle 2.
  - sw: cycle 3.
  - R-type/addi: cycle 3.
  - lw: cycle 4.
- inst_ready is high again in the cycle after done, so back-to-back R-type accepts are 4 cycles apart.
- Register writes and SRAM writes commit on the clock edge ending the done cycle. The next instruction's DEC therefore reads updated values; no hazards are possible.
- The SRAM read is synchronous: address is presented in MEM, data is captured in MDR at the end of MEM.
- rst asserted mid-instruction: returns to IDLE immediately and clears all outputs. Any register/SRAM write scheduled for that edge is suppressed; SRAM keeps prior contents.
- ovf, branch_taken and illegal are never asserted without done.

## Test plan
- Reset, then addi r1,r0,5 (0x20010005) -> done at cycle 3, rd_data=5; then add r2,r1,r1 -> rd_data=10.
- sw r2,8(r0) then lw r3,8(r0) -> sw done at cycle 3; lw done at cycle 4 with rd_data=10. With MEM_DEPTH=256, lw r4,1032(r0) wraps to the same word and returns 10.
- r5=0x7FFFFFFF, then add r6,r5,r5 -> ovf pulse with done; r6 stays 0; rd_data unchanged.
- beq r1,r1 -> branch_taken pulse at cycle 2; beq r1,r2 -> done with branch_taken=0. Then op 111111 -> illegal+done at cycle 1 and no register change. Then addi r0,r0,7 -> r0 still reads 0.
- DW=16, NREG=8: addi with imm 0xFFFF -> rd_data=0xFFFF. Register field 9 aliases register 1. slt -1,1 -> 1.
- Assert rst during EX of add, then during MEM of sw -> outputs at reset values; target register and SRAM word unchanged; inst_valid held during busy is ignored.
